// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: default datapath width, fp32 zero, and the
// tag that rides alongside each operand beat through the MAC pipeline.
package gemm_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SLOT_W = 8;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic              valid;
        logic [SLOT_W-1:0] slot;
        logic              last;
    } psum_tag_t;

endpackage

// File: rtl/mac_psum_out_fifo.sv
// Result buffer for finished accumulations; count is a register so the
// parent can derive backpressure from it without a combinational loop.
module mac_psum_out_fifo
    import gemm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Backpressure upstream guarantees neither of these can happen.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && count == CW'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && count == '0));

endmodule

// File: rtl/mac_psum_ctrl.sv
// Interleaved partial-sum controller feeding an external fixed-latency
// fp multiply-add; finished sums are buffered for the consumer.
module mac_psum_ctrl
    import gemm_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAC_LATENCY = 4,
    parameter int NUM_ACC     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic [DATA_W-1:0] mac_c,
    input  logic [DATA_W-1:0] mac_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int SW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam int CW = $clog2(NUM_ACC + 1);

    if (NUM_ACC < MAC_LATENCY) begin : g_bad_cfg
        $error("mac_psum_ctrl: NUM_ACC must be >= MAC_LATENCY");
    end

    logic [SW-1:0]     ptr;
    psum_tag_t         tags [MAC_LATENCY];
    psum_tag_t         tail;
    logic [DATA_W-1:0] psum [NUM_ACC];
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       inflight;
    logic [CW:0]       pending;
    logic              accept;
    logic              wb_psum;
    logic              push;
    logic              pop;

    assign tail    = tags[MAC_LATENCY-1];
    assign wb_psum = tail.valid && !tail.last;
    assign push    = tail.valid && tail.last;
    assign accept  = in_valid && in_ready;
    assign pop     = out_valid && out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MAC_LATENCY; i++) begin
            if (tags[i].valid && tags[i].last) inflight = inflight + (CW+1)'(1);
        end
    end

    // Every in-flight last beat already owns a future FIFO entry.
    assign pending  = {1'b0, fifo_count} + inflight;
    assign in_ready = !rst && (pending < (CW+1)'(NUM_ACC));

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        if (accept) begin
            mac_a = in_a;
            mac_b = in_b;
            if (in_first)
                mac_c = DATA_W'(FP32_ZERO);
            else if (wb_psum && tail.slot == SLOT_W'(ptr))
                mac_c = mac_z;
            else
                mac_c = psum[ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < MAC_LATENCY; i++) tags[i] <= '0;
        end else begin
            if (accept) ptr <= (ptr == SW'(NUM_ACC - 1)) ? '0 : ptr + SW'(1);
            tags[0] <= '{valid: accept, slot: SLOT_W'(ptr), last: in_last};
            for (int i = 1; i < MAC_LATENCY; i++) tags[i] <= tags[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) psum[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (wb_psum && tail.slot == SLOT_W'(i)) psum[i] <= mac_z;
            end
        end
    end

    mac_psum_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (NUM_ACC)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mac_z),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mac_psum_ctrl.sv
// Bench for mac_psum_ctrl with a fixed-latency fp multiply-add model
// and a per-slot real-arithmetic accumulation reference.
module tb_mac_psum_ctrl;

    localparam int DW = 32;
    localparam int L  = 4;
    localparam int N  = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_first;
    logic          in_last;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [DW-1:0] mac_c;
    logic [DW-1:0] mac_z;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    mac_psum_ctrl #(
        .DATA_W      (DW),
        .MAC_LATENCY (L),
        .NUM_ACC     (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_z     (mac_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // Downstream mac_fp: z = a*b + c, L cycles after operands are presented.
    logic [DW-1:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= r2f(f2r(mac_a) * f2r(mac_b) + f2r(mac_c));
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mac_z = pipe[L-1];

    typedef struct {
        logic [31:0] v;
        int          t;
    } exp_t;

    real         acc_m [N];
    int          ptr_m;
    int          outstanding;
    exp_t        expq [$];
    logic [31:0] gotv [$];
    int          gott [$];
    int          cyc;
    int          ordy_mode;
    int          checks;
    int          failures;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) acc_m[i] = 0.0;
        ptr_m = 0;
        outstanding = 0;
        expq.delete();
    endtask

    task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input bit f, input bit l, output bit acc);
        real p;
        @(negedge clk);
        cyc++;
        in_valid = v;
        in_a = a;
        in_b = b;
        in_first = f;
        in_last = l;
        out_ready = (ordy_mode == 0) ? 1'b0 :
                    (ordy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, outstanding < N});
        chk("out_valid", {31'd0, out_valid},
            {31'd0, expq.size() > 0 && cyc >= expq[0].t});
        if (out_valid && out_ready) begin
            if (expq.size() > 0) begin
                chk("out_data", out_data, expq[0].v);
                void'(expq.pop_front());
                outstanding--;
            end else begin
                checks++;
                failures++;
                $display("FAIL pop_empty: got %h expected none", out_data);
            end
            gotv.push_back(out_data);
            gott.push_back(cyc);
        end
        acc = v && in_ready;
        if (acc) begin
            chk("mac_a", mac_a, a);
            chk("mac_b", mac_b, b);
            chk("mac_c", mac_c, f ? 32'h0 : r2f(acc_m[ptr_m]));
            p = f2r(a) * f2r(b);
            acc_m[ptr_m] = (f ? 0.0 : acc_m[ptr_m]) + p;
            if (l) begin
                expq.push_back('{v: r2f(acc_m[ptr_m]), t: cyc + L + 1});
                outstanding++;
            end
            ptr_m = (ptr_m + 1) % N;
        end else begin
            chk("mac_idle", mac_a | mac_b | mac_c, 32'h0);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input bit f, input bit l, input int vpct);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 300) begin
            cycle($urandom_range(1, 100) <= vpct, a, b, f, l, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 32'h0, 32'h0, 0, 0, acc);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        ordy_mode = 1;
        while (expq.size() > 0 && n < 500) begin
            cycle(0, 32'h0, 32'h0, 0, 0, acc);
            n++;
        end
        checks++;
        if (expq.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d left expected 0", expq.size());
        end
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_mac", mac_a | mac_b | mac_c, 32'h0);
        repeat (2) @(negedge clk);
        model_clear();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'h1);
    endtask

    task automatic check_all(input string name, input logic [31:0] v, input int n);
        chk({name, "_count"}, gotv.size(), n);
        foreach (gotv[i]) chk(name, gotv[i], v);
    endtask

    logic [31:0] t4_exp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                32'h40800000, 32'h40A00000, 32'h40C00000,
                                32'h40E00000, 32'h41000000};

    initial begin
        int ta;
        int k;
        int rem [N];
        bit acc;
        bit f;
        bit l;
        checks = 0;
        failures = 0;
        cyc = 0;
        ordy_mode = 1;
        rst = 1'b1;
        in_valid = 0;
        in_a = 0;
        in_b = 0;
        in_first = 0;
        in_last = 0;
        out_ready = 0;
        model_clear();
        do_reset();

        // K=1: 2.0 * 3.0
        gotv.delete();
        gott.delete();
        send(32'h40000000, 32'h40400000, 1, 1, 100);
        ta = cyc;
        drain();
        chk("k1_count", gotv.size(), 1);
        if (gotv.size() > 0) begin
            chk("k1_data", gotv[0], 32'h40C00000);
            chk("k1_latency", gott[0] - ta, L + 1);
        end

        // Four slots, K=3, continuous.
        gotv.delete();
        for (int i = 0; i < 12; i++) send(32'h3F800000, 32'h3F800000, i < 4, i >= 8, 100);
        drain();
        check_all("k3", 32'h40400000, 4);

        // K=2 stream exercising the write-back bypass.
        gotv.delete();
        for (int i = 0; i < 16; i++)
            send(32'h40000000, 32'h40000000, (i % 8) < 4, (i % 8) >= 4, 100);
        drain();
        check_all("k2_bypass", 32'h41000000, 8);

        // Output stalled: only NUM_ACC results may be outstanding.
        gotv.delete();
        ordy_mode = 0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(k < 8, r2f(real'(k + 1)), 32'h3F800000, 1, 1, acc);
            if (acc) k++;
        end
        chk("stall_accepts", k, 4);
        chk("stall_in_ready", {31'd0, in_ready}, 32'h0);
        ordy_mode = 1;
        while (k < 8) begin
            send(r2f(real'(k + 1)), 32'h3F800000, 1, 1, 100);
            k++;
        end
        drain();
        chk("stall_count", gotv.size(), 8);
        foreach (gotv[i]) if (i < 8) chk("stall_order", gotv[i], t4_exp[i]);

        // Toggling in_valid during K=3 groups.
        gotv.delete();
        for (int i = 0; i < 12; i++) begin
            idle(1);
            send(32'h3F800000, 32'h3F800000, i < 4, i >= 8, 100);
        end
        drain();
        check_all("toggle", 32'h40400000, 4);

        // Reset with results buffered and beats in flight.
        ordy_mode = 0;
        send(32'h40A00000, 32'h3F800000, 1, 1, 100);
        send(32'h40C00000, 32'h3F800000, 1, 1, 100);
        idle(L + 2);
        for (int i = 0; i < 3; i++) send(32'h40000000, 32'h40000000, 1, 0, 100);
        do_reset();
        gotv.delete();
        ordy_mode = 1;
        send(32'h3F800000, 32'h3F800000, 1, 1, 100);
        drain();
        check_all("after_rst", 32'h3F800000, 1);

        // Randomized groups per slot with random valid and out_ready.
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        ordy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            f = (rem[ptr_m] == 0);
            if (f) rem[ptr_m] = $urandom_range(1, 4);
            l = (rem[ptr_m] == 1);
            rem[ptr_m]--;
            send(r2f(real'($urandom_range(0, 7))), r2f(real'($urandom_range(0, 7))),
                 f, l, 60);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
